// File: rtl/fnd_pkg.sv
// Shared types, sizes and helpers for the FND scan controller.
package fnd_pkg;

  localparam int unsigned N_DIGITS     = 4;
  localparam int unsigned VAL_W        = 14;
  localparam int unsigned NIB_W        = 4;
  localparam int unsigned BCD_W        = N_DIGITS * NIB_W;
  localparam int unsigned MAX_VALUE    = 9999;
  localparam int unsigned SHIFT_CYCLES = 14;
  localparam int unsigned CNT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Active-low digit selects; element i drives position i low.
  localparam logic [NIB_W-1:0] DIG_OFF = 4'b1111;
  localparam logic [N_DIGITS-1:0][NIB_W-1:0] DIG_SEL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (bcd[i*NIB_W +: NIB_W] >= 4'd5) begin
        r[i*NIB_W +: NIB_W] = bcd[i*NIB_W +: NIB_W] + 4'd3;
      end
    end
    return r;
  endfunction

  // Leading-zero test: position idx>0 is blank when it and all higher nibbles are zero.
  function automatic logic is_blank(input logic [BCD_W-1:0] bcd, input logic [1:0] idx);
    if (idx == 2'd0) begin
      return 1'b0;
    end
    return (bcd >> {idx, 2'b00}) == '0;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter, one shift-add step per cycle.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [VAL_W-1:0] i_value,
  output logic             o_busy,
  output logic             o_done,
  output logic [BCD_W-1:0] o_bcd
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [VAL_W-1:0]   bin_q,   bin_d;
  logic [BCD_W-1:0]   bcd_q,   bcd_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  // Next-state and datapath: capture on start, 14 dabble steps, one DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SHIFT;
          bin_d   = i_value;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {dabble_adjust(bcd_q), bin_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SHIFT_CYCLES - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_bcd  = bcd_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit multiplexed FND driver: binary load, BCD conversion, scan and blanking.
module fnd_scan_controller #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned N_DIGITS = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_Load,
  input  logic [fnd_pkg::VAL_W-1:0] i_Value,
  output logic                      o_Busy,
  output logic                      o_Done,
  output logic                      o_Ovf,
  output logic [3:0]                o_Value,
  output logic                      o_Dec_EN,
  output logic [3:0]                o_Digit
);

  import fnd_pkg::*;

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(N_DIGITS);

  logic             conv_busy;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic             start_c;
  logic [VAL_W-1:0] clamp_c;

  logic             ovf_q,   ovf_d;
  logic [BCD_W-1:0] disp_q,  disp_d;
  logic [PRE_W-1:0] pre_q,   pre_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [NIB_W-1:0] value_q, value_d;
  logic [NIB_W-1:0] digit_q, digit_d;

  // Loads are only honoured while the converter is idle; out-of-range values saturate.
  assign start_c = i_Load & ~conv_busy;
  assign clamp_c = (i_Value > VAL_W'(MAX_VALUE)) ? VAL_W'(MAX_VALUE) : i_Value;

  bin2bcd_seq u_bin2bcd (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (start_c),
    .i_value   (clamp_c),
    .o_busy    (conv_busy),
    .o_done    (conv_done),
    .o_bcd     (conv_bcd)
  );

  // Overflow flag, display commit, scan prescaler and registered digit outputs.
  always_comb begin
    ovf_d = ovf_q;
    if (start_c) begin
      ovf_d = (i_Value > VAL_W'(MAX_VALUE));
    end

    disp_d = conv_done ? conv_bcd : disp_q;

    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    // Outputs are derived from the next-cycle display and index so they line up with them.
    value_d = disp_d[{idx_d, 2'b00} +: NIB_W];
    digit_d = is_blank(disp_d, idx_d) ? DIG_OFF : DIG_SEL[idx_d];
  end

  // Registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ovf_q   <= 1'b0;
      disp_q  <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      value_q <= 4'h0;
      digit_q <= 4'b1110;
    end else begin
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      digit_q <= digit_d;
    end
  end

  assign o_Busy   = conv_busy;
  assign o_Done   = conv_done;
  assign o_Ovf    = ovf_q;
  assign o_Value  = value_q;
  assign o_Digit  = digit_q;
  assign o_Dec_EN = 1'b0;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with a short scan period.
module tb_fnd_scan_controller;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_Load;
  logic [13:0] i_Value;
  logic        o_Busy;
  logic        o_Done;
  logic        o_Ovf;
  logic [3:0]  o_Value;
  logic        o_Dec_EN;
  logic [3:0]  o_Digit;

  int n_checks = 0;
  int n_pass   = 0;

  fnd_scan_controller #(
    .SCAN_DIV (4),
    .N_DIGITS (4)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_Load    (i_Load),
    .i_Value   (i_Value),
    .o_Busy    (o_Busy),
    .o_Done    (o_Done),
    .o_Ovf     (o_Ovf),
    .o_Value   (o_Value),
    .o_Dec_EN  (o_Dec_EN),
    .o_Digit   (o_Digit)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_load(input logic [13:0] v);
    i_Load  = 1'b1;
    i_Value = v;
    tick();
    i_Load  = 1'b0;
  endtask

  // Wait (bounded) for the done pulse, then step into the cycle where digits are visible.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (o_Done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, o_Done, 1);
    tick();
    check({tag, "_idle_after"}, o_Busy, 0);
  endtask

  // Count done pulses over a window where none may occur.
  task automatic no_done(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (o_Done === 1'b1) pulses++;
      tick();
    end
    check({tag, "_no_done"}, pulses, 0);
  endtask

  // Align to the start of the units slot, then check one full frame cycle by cycle.
  task automatic scan_check(input string tag, input logic [15:0] bcd, input logic [3:0] blank);
    int n;
    logic [3:0] sel;
    logic [3:0] exp_dig;
    n = 0;
    while (o_Digit === 4'b1110 && n < 8) begin
      tick();
      n++;
    end
    n = 0;
    while (o_Digit !== 4'b1110 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_sync"}, o_Digit, 4'b1110);
    for (int s = 0; s < 4; s++) begin
      sel     = 4'b0001 << s;
      exp_dig = blank[s] ? 4'b1111 : ~sel;
      for (int c = 0; c < 4; c++) begin
        check($sformatf("%s_dig%0d_c%0d", tag, s, c), o_Digit, exp_dig);
        check($sformatf("%s_val%0d_c%0d", tag, s, c), o_Value, bcd[s*4 +: 4]);
        tick();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset_n = 1'b0;
    i_Load    = 1'b0;
    i_Value   = '0;
    repeat (3) tick();

    check("rst_busy",   o_Busy,   0);
    check("rst_done",   o_Done,   0);
    check("rst_ovf",    o_Ovf,    0);
    check("rst_value",  o_Value,  4'h0);
    check("rst_digit",  o_Digit,  4'b1110);
    check("rst_dec_en", o_Dec_EN, 0);

    i_reset_n = 1'b1;
    scan_check("idle0", 16'h0000, 4'b1110);

    // Exact latency of a conversion.
    do_load(14'd1234);
    check("l1234_busy_k1", o_Busy, 1);
    check("l1234_done_k1", o_Done, 0);
    for (int j = 1; j <= 15; j++) begin
      tick();
      check($sformatf("l1234_done_e%0d", j), o_Done, (j == 14));
      check($sformatf("l1234_busy_e%0d", j), o_Busy, (j <= 14));
    end
    check("l1234_ovf", o_Ovf, 0);
    check("l1234_value_now", o_Value, 4'h4);
    scan_check("v1234", 16'h1234, 4'b0000);

    // Saturation of an out-of-range value.
    do_load(14'd12000);
    check("l12000_ovf", o_Ovf, 1);
    wait_done("l12000");
    check("l12000_ovf_hold", o_Ovf, 1);
    scan_check("v9999", 16'h9999, 4'b0000);

    // Load while busy is dropped.
    do_load(14'd5);
    check("l5_ovf", o_Ovf, 0);
    tick();
    tick();
    i_Load  = 1'b1;
    i_Value = 14'd7;
    tick();
    i_Load  = 1'b0;
    wait_done("l5");
    no_done("l5_drop", 20);
    check("l5_busy_after", o_Busy, 0);
    check("l5_ovf_after", o_Ovf, 0);
    scan_check("v5", 16'h0005, 4'b1110);

    // Reset in the middle of a conversion aborts it.
    do_load(14'd305);
    repeat (7) tick();
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    check("abort_busy",  o_Busy,  0);
    check("abort_digit", o_Digit, 4'b1110);
    check("abort_value", o_Value, 4'h0);
    no_done("abort", 20);
    check("abort_busy_late", o_Busy, 0);
    scan_check("abort_v0", 16'h0000, 4'b1110);

    // Load on the very first edge after reset release.
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    i_Load    = 1'b1;
    i_Value   = 14'd1000;
    tick();
    i_Load    = 1'b0;
    check("l1000_accept", o_Busy, 1);
    wait_done("l1000");
    scan_check("v1000", 16'h1000, 4'b0000);

    do_load(14'd0);
    check("l0_accept", o_Busy, 1);
    wait_done("l0");
    scan_check("v0", 16'h0000, 4'b1110);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
